uart_rgb_cmd: RTL
=================

// Module: uart_rgb_cmd
// PURPOSE
//  Command stage downstream of the simpleuart receive/transmit register port.
//  Polls received bytes, decodes single-character ASCII colour and brightness
//  commands, and sends a one-byte acknowledge back through the same port.
//  Drives the PWM enables (rgb_red/green/blue) feeding the SB_RGBA_DRV
//  primitive. Replaces ad-hoc decode logic in the top level.
// PARAMETERS
//  PWM_DIV  750  hw_clk cycles per PWM tick; 16 ticks per PWM period (1 kHz at 12 MHz)
//  ACK_EN   1    1: send acknowledge byte per command; 0: silent, never asserts reg_dat_we
// PORTS
//  hw_clk        in   1   single clock, all logic on posedge
//  reset         in   1   asynchronous, active-high reset
//  reg_dat_do    in   32  uart rx data; 32'hFFFF_FFFF = no byte, else {24'b0, byte}
//  reg_dat_wait  in   1   uart tx busy; write accepted on cycle with we=1 && wait=0
//  reg_dat_re    out  1   one-cycle pulse; consumes the current rx byte
//  reg_dat_we    out  1   tx write request; held until accepted
//  reg_dat_di    out  32  tx data {24'b0, byte}; stable while reg_dat_we=1
//  rgb_red       out  1   PWM enable, red channel
//  rgb_green     out  1   PWM enable, green channel
//  rgb_blue      out  1   PWM enable, blue channel
//  busy          out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; reg_dat_re=0; reg_dat_we=0; reg_dat_di=0; busy=0
//   - colour[2:0]={b,g,r}=3'b000; bright=4'hF; PWM prescaler and counter=0
//   - all rgb outputs=0
//  Reset asserted mid-operation aborts any pending write or argument immediately.
//  FSM states: IDLE, DECODE, ARG, ARG_DEC, TX.
//  IDLE / ARG:
//   - if reg_dat_do != 32'hFFFF_FFFF: latch byte=do[7:0] and pulse reg_dat_re for 1 cycle
//   - next state: DECODE from IDLE, ARG_DEC from ARG; otherwise remain
//  DECODE (cycle after the re pulse):
//   - '0'..'7': colour <= byte[2:0]; ack = byte
//   - 'B':      no ack; go to ARG
//   - '?':      ack = "0"+colour
//   - other:    ack = "E"; colour and brightness unchanged
//  ARG_DEC:
//   - '0'-'9', 'A'-'F', 'a'-'f': bright <= hex value; ack = "K"
//   - other: ack = "E"; bright unchanged
//  Ack path:
//   - ACK_EN=1: reg_dat_di <= ack and reg_dat_we <= 1, enter TX
//   - ACK_EN=0: return to IDLE; colour and bright still update
//  TX: hold we and di; on first cycle with wait=0, deassert we next edge, go IDLE.
//   - wait=0 already on entry -> we is high for exactly 1 cycle
//  Rx spacing: minimum 2 cycles between re pulses, so a byte is never read twice
//   (do updates to -1 one cycle after re).
//  PWM:
//   - prescaler counts 0..PWM_DIV-1; on wrap, pwm_cnt (4b) increments, wrapping 15->0
//   - rgb_x = registered (colour[x] && pwm_cnt < bright)
//   - bright=0 -> off; bright=15 -> 15/16 duty
//   - colour/bright changes take effect at the next hw_clk edge; no period resync
//  Bytes arriving during TX are left in the uart (not consumed) until IDLE.
// TESTING
//  T1 reset: assert reset mid-TX -> we=0, di=0, rgb=000, bright=F same cycle (async)
//  T2 rx '5' (0x35), wait=0 -> re pulse 1 cycle; colour=101; di=0x35, we high 1 cycle
//  T3 rx 'B' then '8' -> no ack after 'B'; bright=8; ack 'K'; red duty 8/16 with colour=001
//  T4 rx 'B' then 'x' -> ack 'E', bright stays F; next '?' with colour=101 -> ack '5'
//  T5 wait held high 20 cycles in TX -> we and di stable 20 cycles; drop after accept
//  T6 ACK_EN=0, back-to-back '1','2' -> we never asserts; exactly 2 re pulses; colour=010

Source files
------------

// File: rtl/uart_rgb_cmd.sv
// Single-character command stage for the UART register port. It polls the
// receive byte, decodes colour and brightness commands, sends a one-byte
// acknowledge, and generates the PWM enables for the RGB driver.
`timescale 1ns/1ps
module uart_rgb_cmd #(
   parameter int unsigned PWM_DIV = 750,
   parameter bit          ACK_EN  = 1'b1
) (
   input  logic        hw_clk,
   input  logic        reset,
   input  logic [31:0] reg_dat_do,
   input  logic        reg_dat_wait,
   output logic        reg_dat_re,
   output logic        reg_dat_we,
   output logic [31:0] reg_dat_di,
   output logic        rgb_red,
   output logic        rgb_green,
   output logic        rgb_blue,
   output logic        busy
);

   localparam int unsigned PS_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_DIV - 1);
   localparam logic [31:0] RX_NONE = 32'hFFFF_FFFF;
   localparam logic [7:0]  CH_ZERO = 8'h30;
   localparam logic [7:0]  CH_B    = 8'h42;
   localparam logic [7:0]  CH_QM   = 8'h3F;
   localparam logic [7:0]  CH_E    = 8'h45;
   localparam logic [7:0]  CH_K    = 8'h4B;

   typedef enum logic [2:0] {IDLE, DECODE, ARG, ARG_DEC, TX} state_t;

   state_t          state;
   logic [7:0]      rx_byte;
   logic [2:0]      colour;
   logic [3:0]      bright;
   logic [PS_W-1:0] pwm_ps;
   logic [3:0]      pwm_cnt;
   logic [4:0]      hex_c;
   logic [7:0]      ack_c;

   // {valid, value} for an ASCII hex digit
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39)      return {1'b1, 4'(b - 8'h30)};
      else if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
      else if (b >= 8'h61 && b <= 8'h66) return {1'b1, 4'(b - 8'h57)};
      else                               return 5'b0_0000;
   endfunction

   assign hex_c = hex_decode(rx_byte);

   // Acknowledge byte for the command currently being decoded
   always_comb begin
      ack_c = CH_E;
      if (state == DECODE) begin
         if (rx_byte[7:3] == 5'b00110) ack_c = rx_byte;
         else if (rx_byte == CH_QM)    ack_c = CH_ZERO + {5'b0_0000, colour};
      end else if (hex_c[4]) begin
         ack_c = CH_K;
      end
   end

   // Command FSM: rx polling, decode, acknowledge handshake
   always_ff @(posedge hw_clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rx_byte    <= 8'h00;
         colour     <= 3'b000;
         bright     <= 4'hF;
         reg_dat_re <= 1'b0;
         reg_dat_we <= 1'b0;
         reg_dat_di <= 32'h0;
         busy       <= 1'b0;
      end else begin
         reg_dat_re <= 1'b0;
         case (state)
            IDLE, ARG: begin
               if (reg_dat_do != RX_NONE) begin
                  rx_byte    <= reg_dat_do[7:0];
                  reg_dat_re <= 1'b1;
                  busy       <= 1'b1;
                  state      <= (state == IDLE) ? DECODE : ARG_DEC;
               end
            end
            DECODE, ARG_DEC: begin
               if (state == DECODE && rx_byte[7:3] == 5'b00110) colour <= rx_byte[2:0];
               if (state == ARG_DEC && hex_c[4])                bright <= hex_c[3:0];
               if (state == DECODE && rx_byte == CH_B) begin
                  state <= ARG;
               end else if (ACK_EN) begin
                  reg_dat_di <= {24'h0, ack_c};
                  reg_dat_we <= 1'b1;
                  state      <= TX;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            TX: begin
               if (!reg_dat_wait) begin
                  reg_dat_we <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // PWM timebase and registered channel enables
   always_ff @(posedge hw_clk or posedge reset) begin
      if (reset) begin
         pwm_ps    <= '0;
         pwm_cnt   <= 4'h0;
         rgb_red   <= 1'b0;
         rgb_green <= 1'b0;
         rgb_blue  <= 1'b0;
      end else begin
         if (pwm_ps == PS_LAST) begin
            pwm_ps  <= '0;
            pwm_cnt <= pwm_cnt + 4'h1;
         end else begin
            pwm_ps <= pwm_ps + PS_W'(1);
         end
         rgb_red   <= colour[0] && (pwm_cnt < bright);
         rgb_green <= colour[1] && (pwm_cnt < bright);
         rgb_blue  <= colour[2] && (pwm_cnt < bright);
      end
   end

endmodule
